// File: rtl/spi_apb_pkg.sv
// rtl/spi_apb_pkg.sv - shared types and constants for the SPI-to-APB command master
package spi_apb_pkg;

    // FSM states of the command master
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DATA   = 3'd3,
        ST_SETUP  = 3'd4,
        ST_ACCESS = 3'd5
    } state_e;

    // Command byte layout: {rd, inc, rsvd[1:0], addr[11:8]}
    localparam int CMD_RD_BIT  = 7;
    localparam int CMD_INC_BIT = 6;

    // Byte handed back to the SPI shifter when a read fails
    localparam logic [7:0] ERR_BYTE_DEF = 8'hEE;

endpackage

// File: rtl/spi_apb_cmd_master_if.sv
// rtl/spi_apb_cmd_master_if.sv - SPI byte stream and APB bus bundle
// master modport: the command master (drives APB, consumes rx bytes, produces tx bytes)
// slave modport : SPI shifter + APB register bank side
interface spi_apb_cmd_master_if #(
    parameter int ADDR_W = 12
) ();
    // SPI byte side
    logic              spi_frame;
    logic              rx_valid;
    logic [7:0]        rx_byte;
    logic [7:0]        tx_byte;
    logic              tx_valid;
    // APB side
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [7:0]        pwdata;
    logic              pstrb;
    logic [2:0]        pprot;
    logic              pready_ack;
    logic [7:0]        prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  spi_frame, rx_valid, rx_byte, prdata, pready, pslverr,
        output tx_byte, tx_valid, psel, penable, pwrite, paddr, pwdata,
               pstrb, pprot, pready_ack
    );

    modport slave (
        output spi_frame, rx_valid, rx_byte, prdata, pready, pslverr,
        input  tx_byte, tx_valid, psel, penable, pwrite, paddr, pwdata,
               pstrb, pprot, pready_ack
    );
endinterface

// File: rtl/apb_timeout_cnt.sv
// rtl/apb_timeout_cnt.sv - ACCESS-phase watchdog counter
// Ports: clk, rst_n (async active-low), clr_i (restart), en_i (count this cycle),
//        expire_o (high on the TIMEOUT_CYC-th enabled cycle since clear)
module apb_timeout_cnt #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int W = $clog2(TIMEOUT_CYC + 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // cnt_q holds the number of enabled cycles already elapsed, so the
    // TIMEOUT_CYC-th enabled cycle sees TIMEOUT_CYC-1 and expires.
    assign expire_o = en_i && (cnt_q == W'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expire_o) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/spi_apb_cmd_master.sv
// rtl/spi_apb_cmd_master.sv - turns CS-framed SPI command bytes into APB byte transfers
// Ports: cpu_clk, presetn (async active-low), bus (spi_apb_cmd_master_if.master:
//        SPI rx/tx bytes + APB master), busy, sticky err_overrun/err_timeout/err_slv,
//        err_clr (clears the sticky flags, a same-cycle set wins)
module spi_apb_cmd_master
    import spi_apb_pkg::*;
#(
    parameter int         ADDR_W      = 12,
    parameter int         TIMEOUT_CYC = 16,
    parameter logic [7:0] ERR_BYTE    = ERR_BYTE_DEF
) (
    input  logic                  cpu_clk,
    input  logic                  presetn,
    spi_apb_cmd_master_if.master  bus,
    output logic                  busy,
    output logic                  err_overrun,
    output logic                  err_timeout,
    output logic                  err_slv,
    input  logic                  err_clr
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_q, rd_d;
    logic              inc_q, inc_d;
    logic              pwrite_q, pwrite_d;
    logic [7:0]        pwdata_q, pwdata_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              tx_valid_q, tx_valid_d;
    logic              lost_q, lost_d;
    logic              ovr_q, to_q, slv_q;
    logic              set_ovr, set_to, set_slv;
    logic              cnt_clr, cnt_en, cnt_expire;
    logic              done;
    logic [7:0]        rdata;

    apb_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk      (cpu_clk),
        .rst_n    (presetn),
        .clr_i    (cnt_clr),
        .en_i     (cnt_en),
        .expire_o (cnt_expire)
    );

    // Bus controls decode straight from the state register so an async reset
    // drops psel/penable in the same instant.
    assign bus.psel       = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign bus.penable    = (state_q == ST_ACCESS);
    assign bus.pready_ack = (state_q == ST_ACCESS);
    assign bus.pstrb      = bus.psel;
    assign bus.pprot      = 3'b000;
    assign bus.pwrite     = pwrite_q;
    assign bus.paddr      = addr_q;
    assign bus.pwdata     = pwdata_q;
    assign bus.tx_byte    = tx_byte_q;
    assign bus.tx_valid   = tx_valid_q;

    assign busy        = (state_q != ST_IDLE);
    assign err_overrun = ovr_q;
    assign err_timeout = to_q;
    assign err_slv     = slv_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rd_d       = rd_q;
        inc_d      = inc_q;
        pwrite_d   = pwrite_q;
        pwdata_d   = pwdata_q;
        tx_byte_d  = tx_byte_q;
        tx_valid_d = 1'b0;
        lost_d     = lost_q;
        set_ovr    = 1'b0;
        set_to     = 1'b0;
        set_slv    = 1'b0;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        done       = 1'b0;
        rdata      = bus.prdata;

        unique case (state_q)
            ST_IDLE: begin
                lost_d = 1'b0;
                if (bus.spi_frame) state_d = ST_CMD;
            end
            ST_CMD: begin
                if (!bus.spi_frame) begin
                    state_d = ST_IDLE;
                end else if (bus.rx_valid) begin
                    rd_d    = bus.rx_byte[CMD_RD_BIT];
                    inc_d   = bus.rx_byte[CMD_INC_BIT];
                    addr_d  = ADDR_W'({bus.rx_byte[3:0], 8'h00});
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (!bus.spi_frame) begin
                    state_d = ST_IDLE;
                end else if (bus.rx_valid) begin
                    addr_d[7:0] = bus.rx_byte;
                    if (rd_q) begin
                        // First read is prefetched as soon as the address is known
                        pwrite_d = 1'b0;
                        state_d  = ST_SETUP;
                    end else begin
                        state_d  = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (!bus.spi_frame) begin
                    state_d = ST_IDLE;
                end else if (bus.rx_valid) begin
                    pwrite_d = !rd_q;
                    if (!rd_q) pwdata_d = bus.rx_byte;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_clr = 1'b0 == 1'b0;
                if (bus.rx_valid) set_ovr = 1'b1;
                if (!bus.spi_frame) lost_d = 1'b1;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                cnt_en = 1'b1;
                if (bus.rx_valid) set_ovr = 1'b1;
                if (!bus.spi_frame) lost_d = 1'b1;
                if (bus.pready) begin
                    done = 1'b1;
                    if (bus.pslverr) begin
                        set_slv = 1'b1;
                        rdata   = ERR_BYTE;
                    end
                end else if (cnt_expire) begin
                    done   = 1'b1;
                    set_to = 1'b1;
                    rdata  = ERR_BYTE;
                end
                if (done) begin
                    if (inc_q) addr_d = addr_q + ADDR_W'(1);
                    // A frame that dropped at any point during the transfer gets no reply
                    if (bus.spi_frame && !lost_q) begin
                        state_d = ST_DATA;
                        if (rd_q) begin
                            tx_byte_d  = rdata;
                            tx_valid_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk or negedge presetn) begin
        if (!presetn) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rd_q       <= 1'b0;
            inc_q      <= 1'b0;
            pwrite_q   <= 1'b0;
            pwdata_q   <= 8'h00;
            tx_byte_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            lost_q     <= 1'b0;
            ovr_q      <= 1'b0;
            to_q       <= 1'b0;
            slv_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rd_q       <= rd_d;
            inc_q      <= inc_d;
            pwrite_q   <= pwrite_d;
            pwdata_q   <= pwdata_d;
            tx_byte_q  <= tx_byte_d;
            tx_valid_q <= tx_valid_d;
            lost_q     <= lost_d;
            ovr_q      <= (ovr_q && !err_clr) || set_ovr;
            to_q       <= (to_q  && !err_clr) || set_to;
            slv_q      <= (slv_q && !err_clr) || set_slv;
        end
    end
endmodule

// File: tb/tb_spi_apb_cmd_master.sv
// tb/tb_spi_apb_cmd_master.sv - scoreboard bench for spi_apb_cmd_master
module tb_spi_apb_cmd_master;
    typedef struct packed {
        logic        wr;
        logic [11:0] addr;
        logic [7:0]  data;
    } xfer_t;

    logic cpu_clk = 1'b0;
    logic presetn = 1'b0;
    logic err_clr = 1'b0;
    logic busy, err_overrun, err_timeout, err_slv;

    spi_apb_cmd_master_if #(.ADDR_W(12)) bus ();

    spi_apb_cmd_master #(
        .ADDR_W      (12),
        .TIMEOUT_CYC (16),
        .ERR_BYTE    (8'hEE)
    ) dut (
        .cpu_clk     (cpu_clk),
        .presetn     (presetn),
        .bus         (bus),
        .busy        (busy),
        .err_overrun (err_overrun),
        .err_timeout (err_timeout),
        .err_slv     (err_slv),
        .err_clr     (err_clr)
    );

    always #5 cpu_clk = ~cpu_clk;

    int    nvec = 0;
    int    nerr = 0;
    xfer_t exp_apb[$];
    logic [7:0] exp_tx[$];

    // APB slave model knobs
    int         slv_wait  = 0;
    bit         slv_hang  = 1'b0;
    bit         slv_err   = 1'b0;
    logic [7:0] slv_rdata = 8'h00;
    int         acc_cnt   = 0;
    int         last_acc  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // APB slave: answers after slv_wait ACCESS cycles unless hung
    always @(negedge cpu_clk) begin
        if (bus.psel && bus.penable) begin
            if (acc_cnt >= slv_wait && !slv_hang) begin
                bus.pready  = 1'b1;
                bus.prdata  = slv_rdata;
                bus.pslverr = slv_err;
            end else begin
                bus.pready  = 1'b0;
                bus.pslverr = 1'b0;
            end
            acc_cnt++;
        end else begin
            if (acc_cnt != 0) last_acc = acc_cnt;
            acc_cnt     = 0;
            bus.pready  = 1'b0;
            bus.pslverr = 1'b0;
        end
    end

    // Monitor: every SETUP phase and every tx_valid pulse consumes one expectation
    always @(negedge cpu_clk) begin
        if (presetn) begin
            if (bus.psel && !bus.penable) begin
                if (exp_apb.size() == 0) begin
                    chk("unexpected_apb_xfer", {20'h0, bus.paddr}, 32'hFFFF_FFFF);
                end else begin
                    xfer_t e;
                    e = exp_apb.pop_front();
                    chk("apb_pwrite", {31'h0, bus.pwrite}, {31'h0, e.wr});
                    chk("apb_paddr", {20'h0, bus.paddr}, {20'h0, e.addr});
                    if (e.wr) chk("apb_pwdata", {24'h0, bus.pwdata}, {24'h0, e.data});
                end
            end
            if (bus.tx_valid) begin
                if (exp_tx.size() == 0) begin
                    chk("unexpected_tx", {24'h0, bus.tx_byte}, 32'hFFFF_FFFF);
                end else begin
                    logic [7:0] t;
                    t = exp_tx.pop_front();
                    chk("tx_byte", {24'h0, bus.tx_byte}, {24'h0, t});
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input int gap);
        bus.rx_valid = 1'b1;
        bus.rx_byte  = b;
        @(negedge cpu_clk);
        bus.rx_valid = 1'b0;
        repeat (gap) @(negedge cpu_clk);
    endtask

    task automatic frame_on();
        bus.spi_frame = 1'b1;
        @(negedge cpu_clk);
    endtask

    task automatic frame_off();
        bus.spi_frame = 1'b0;
        repeat (4) @(negedge cpu_clk);
    endtask

    task automatic push_x(input logic wr, input logic [11:0] a, input logic [7:0] d);
        xfer_t x;
        x.wr = wr; x.addr = a; x.data = d;
        exp_apb.push_back(x);
    endtask

    initial begin
        bus.spi_frame = 1'b0;
        bus.rx_valid  = 1'b0;
        bus.rx_byte   = 8'h00;
        bus.prdata    = 8'h00;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;

        repeat (3) @(negedge cpu_clk);
        chk("rst_outputs", {24'h0, bus.psel, bus.penable, bus.pwrite, bus.tx_valid, busy,
                            err_overrun, err_timeout, err_slv}, 32'h0);
        chk("rst_tx_byte", {24'h0, bus.tx_byte}, 32'h0);
        chk("rst_paddr", {20'h0, bus.paddr}, 32'h0);
        presetn = 1'b1;
        @(negedge cpu_clk);

        // Write burst with auto-increment: 0x011=A5, 0x012=5A
        slv_wait = 1;
        push_x(1'b1, 12'h011, 8'hA5);
        push_x(1'b1, 12'h012, 8'h5A);
        frame_on(); send(8'h40, 1); send(8'h11, 1); send(8'hA5, 6); send(8'h5A, 6); frame_off();
        chk("wr_no_errors", {29'h0, err_overrun, err_timeout, err_slv}, 32'h0);

        // Read without increment: address byte plus 3 dummies -> 4 reads of 0x004
        slv_wait = 0; slv_rdata = 8'hF3;
        repeat (4) begin push_x(1'b0, 12'h004, 8'h00); exp_tx.push_back(8'hF3); end
        frame_on(); send(8'h80, 1); send(8'h04, 6);
        repeat (3) send(8'h00, 6);
        chk("noinc_paddr", {20'h0, bus.paddr}, 32'h004);
        frame_off();

        // Address wrap: 0xFFF then 0x000, ending at 0x001
        slv_rdata = 8'h3C;
        push_x(1'b0, 12'hFFF, 8'h00); exp_tx.push_back(8'h3C);
        push_x(1'b0, 12'h000, 8'h00); exp_tx.push_back(8'h3C);
        frame_on(); send(8'hCF, 1); send(8'hFF, 6); send(8'h00, 6); frame_off();
        chk("wrap_paddr", {20'h0, bus.paddr}, 32'h001);

        // Timeout: slave never answers, 16 ACCESS cycles then ERR_BYTE
        slv_hang = 1'b1;
        push_x(1'b0, 12'h030, 8'h00); exp_tx.push_back(8'hEE);
        frame_on(); send(8'h80, 1); send(8'h30, 22);
        chk("timeout_flag", {31'h0, err_timeout}, 32'h1);
        chk("timeout_access_len", last_acc, 32'd16);
        frame_off();
        slv_hang = 1'b0;
        err_clr = 1'b1; @(negedge cpu_clk); err_clr = 1'b0;
        chk("timeout_cleared", {31'h0, err_timeout}, 32'h0);

        // Slave error on read
        slv_err = 1'b1; slv_rdata = 8'hF3;
        push_x(1'b0, 12'h050, 8'h00); exp_tx.push_back(8'hEE);
        frame_on(); send(8'h80, 1); send(8'h50, 6); frame_off();
        slv_err = 1'b0;
        chk("slverr_flag", {31'h0, err_slv}, 32'h1);

        // Overrun: second byte lands in SETUP, dropped, single transfer
        slv_wait = 3;
        push_x(1'b1, 12'h020, 8'h77);
        frame_on(); send(8'h00, 1); send(8'h20, 1); send(8'h77, 0); send(8'h99, 8);
        chk("overrun_flag", {31'h0, err_overrun}, 32'h1);
        frame_off();
        chk("slverr_sticky", {31'h0, err_slv}, 32'h1);
        err_clr = 1'b1; @(negedge cpu_clk); err_clr = 1'b0;
        chk("errs_cleared", {29'h0, err_overrun, err_timeout, err_slv}, 32'h0);

        // Frame holding only the command byte: no APB activity
        frame_on(); send(8'h80, 3); frame_off();
        chk("cmd_only_idle", {31'h0, busy}, 32'h0);

        // Frame drops during ACCESS: transfer completes, no tx reply
        slv_wait = 5;
        push_x(1'b0, 12'h040, 8'h00);
        frame_on(); send(8'h80, 1); send(8'h40, 2);
        chk("drop_in_access", {30'h0, bus.psel, bus.penable}, 32'h3);
        frame_off(); repeat (6) @(negedge cpu_clk);
        chk("drop_idle", {31'h0, busy}, 32'h0);

        // Async reset in the middle of ACCESS
        slv_hang = 1'b1; slv_wait = 0;
        push_x(1'b1, 12'h060, 8'hAB);
        frame_on(); send(8'h00, 1); send(8'h60, 1); send(8'hAB, 2);
        chk("pre_reset_access", {31'h0, bus.penable}, 32'h1);
        presetn = 1'b0;
        #1;
        chk("reset_drops_bus", {29'h0, bus.psel, bus.penable, busy}, 32'h0);
        bus.spi_frame = 1'b0;
        @(negedge cpu_clk);
        presetn = 1'b1; slv_hang = 1'b0;
        repeat (4) @(negedge cpu_clk);

        chk("apb_queue_empty", exp_apb.size(), 32'd0);
        chk("tx_queue_empty", exp_tx.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
